// File: rtl/clique_step_sequencer.sv
// rtl/clique_step_sequencer.sv - vertex-pair schedule controller for the k-clique bit-matrix datapath
// Walks (i, j) pairs issuing separate/merge/scan commands, collects scan hits and streams clique rows out.
module clique_step_sequencer #(
    parameter int N     = 8,
    parameter int IDX_W = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       k,
    input  logic [N*N-1:0]   adj_matrix,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] num_cliques,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [2:0]       cmd_op,
    output logic [IDX_W-1:0] cmd_i,
    output logic [IDX_W-1:0] cmd_j,
    output logic [4:0]       cmd_bit,
    input  logic             rsp_valid,
    input  logic             rsp_hit,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [IDX_W-1:0] res_row
);
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_CHECK    = 4'd1;
    localparam logic [3:0] S_SEP_I    = 4'd2;
    localparam logic [3:0] S_SEP_J    = 4'd3;
    localparam logic [3:0] S_MRG_M    = 4'd4;
    localparam logic [3:0] S_MRG_PP   = 4'd5;
    localparam logic [3:0] S_SCAN     = 4'd6;
    localparam logic [3:0] S_WAIT_RSP = 4'd7;
    localparam logic [3:0] S_EMIT     = 4'd8;
    localparam logic [3:0] S_NEXT     = 4'd9;
    localparam logic [3:0] S_FIN      = 4'd10;

    localparam logic [2:0] OP_SEP_I    = 3'd0;
    localparam logic [2:0] OP_SEP_J    = 3'd1;
    localparam logic [2:0] OP_MERGE_M  = 3'd2;
    localparam logic [2:0] OP_MERGE_PP = 3'd3;
    localparam logic [2:0] OP_SCAN     = 3'd4;

    localparam int EW = IDX_W + 6;
    localparam int AW = $clog2(N * N);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

    logic [3:0]       state_q, state_d;
    logic [4:0]       k_q, k_d;
    logic [N*N-1:0]   adj_q, adj_d;
    logic [IDX_W-1:0] i_q, i_d, j_q, j_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [EW-1:0]    k_ext, i_plus2;
    logic [AW-1:0]    adj_idx;
    logic [IDX_W-1:0] i_inc;
    logic             edge_ij, k_illegal, scan_ok;

    assign k_ext     = EW'(k_q);
    assign i_plus2   = EW'(i_q) + EW'(2);
    assign adj_idx   = AW'(i_q) * AW'(N) + AW'(j_q);
    assign edge_ij   = adj_q[adj_idx];
    assign k_illegal = (k_q < 5'd2) || (k_q > 5'(N));
    // Rows i+2..N-1 exist and the clique still needs at least one more vertex beyond i.
    assign scan_ok   = (k_ext >= i_plus2) && (i_plus2 <= EW'(N - 1));
    assign i_inc     = i_q + ONE;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        adj_d   = adj_q;
        i_d     = i_q;
        j_d     = j_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    k_d     = k;
                    adj_d   = adj_matrix;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (k_illegal) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    i_d     = '0;
                    j_d     = ONE;
                    state_d = S_SEP_I;
                end
            end
            S_SEP_I: if (cmd_ready) state_d = S_SEP_J;
            S_SEP_J: if (cmd_ready) state_d = S_MRG_M;
            S_MRG_M, S_MRG_PP: begin
                if (cmd_ready) begin
                    if (state_q == S_MRG_M && edge_ij) begin
                        state_d = S_MRG_PP;
                    end else if (j_q != LAST) begin
                        j_d     = j_q + ONE;
                        state_d = S_SEP_I;
                    end else if (scan_ok) begin
                        j_d     = IDX_W'(i_plus2);
                        state_d = S_SCAN;
                    end else begin
                        state_d = S_NEXT;
                    end
                end
            end
            S_SCAN: if (cmd_ready) state_d = S_WAIT_RSP;
            S_WAIT_RSP: begin
                if (rsp_valid) begin
                    if (rsp_hit) begin
                        state_d = S_EMIT;
                    end else if (j_q != LAST) begin
                        j_d     = j_q + ONE;
                        state_d = S_SCAN;
                    end else begin
                        state_d = S_NEXT;
                    end
                end
            end
            S_EMIT: begin
                if (res_ready) begin
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    if (j_q != LAST) begin
                        j_d     = j_q + ONE;
                        state_d = S_SCAN;
                    end else begin
                        state_d = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                if (cnt_q != '0 || i_inc == LAST) begin
                    state_d = S_FIN;
                end else begin
                    i_d     = i_inc;
                    j_d     = i_inc + ONE;
                    state_d = S_SEP_I;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            adj_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            adj_q   <= adj_d;
            i_q     <= i_d;
            j_q     <= j_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        cmd_valid = 1'b0;
        cmd_op    = OP_SEP_I;
        cmd_bit   = '0;
        res_valid = 1'b0;
        res_row   = '0;
        case (state_q)
            S_SEP_I:  cmd_valid = 1'b1;
            S_SEP_J:  begin cmd_valid = 1'b1; cmd_op = OP_SEP_J;    end
            S_MRG_M:  begin cmd_valid = 1'b1; cmd_op = OP_MERGE_M;  end
            S_MRG_PP: begin cmd_valid = 1'b1; cmd_op = OP_MERGE_PP; end
            S_SCAN: begin
                cmd_valid = 1'b1;
                cmd_op    = OP_SCAN;
                cmd_bit   = 5'(k_ext - i_plus2);
            end
            S_EMIT: begin
                res_valid = 1'b1;
                res_row   = j_q;
            end
            default: ;
        endcase
    end

    assign cmd_i       = i_q;
    assign cmd_j       = j_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_FIN);
    assign done        = (state_q == S_FIN);
    assign err         = err_q;
    assign num_cliques = cnt_q;
endmodule

// File: tb/tb_clique_step_sequencer.sv
// tb/tb_clique_step_sequencer.sv - randomized self-checking bench for clique_step_sequencer
// A loop-based schedule model predicts command/result streams; a responder answers scans from a hit table.
module tb_clique_step_sequencer;
    localparam int TN    = 4;
    localparam int IW    = 5;
    localparam int CW    = 8;
    localparam int LIMIT = 4000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic            start = 1'b0;
    logic [4:0]      k = '0;
    logic [TN*TN-1:0] adj = '0;
    logic            busy, done, err;
    logic [CW-1:0]   num_cliques;
    logic            cmd_valid;
    logic            cmd_ready = 1'b1;
    logic [2:0]      cmd_op;
    logic [IW-1:0]   cmd_i, cmd_j;
    logic [4:0]      cmd_bit;
    logic            rsp_valid = 1'b0;
    logic            rsp_hit = 1'b0;
    logic            res_valid;
    logic            res_ready = 1'b1;
    logic [IW-1:0]   res_row;

    logic            e8_start = 1'b0;
    logic [4:0]      e8_k = '0;
    logic [63:0]     e8_adj = '0;
    logic            e8_busy, e8_done, e8_err;
    logic [CW-1:0]   e8_num;
    logic            e8_cmd_valid;
    logic [2:0]      e8_cmd_op;
    logic [IW-1:0]   e8_cmd_i, e8_cmd_j, e8_res_row;
    logic [4:0]      e8_cmd_bit;
    logic            e8_res_valid;
    logic            e8_cv_seen = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int n_cmd, n_pp, n_scan, n_res, done_cnt;
    bit rand_mode = 1'b0;
    bit hold_rsp = 1'b0;
    bit pend = 1'b0;
    bit pend_hit = 1'b0;
    int pend_dly = 0;
    bit cs_prev = 1'b0;
    bit rs_prev = 1'b0;
    logic [31:0] cs_fields, rs_fields;
    logic [TN*TN-1:0] hit_v = '0;

    logic [17:0]   exp_cmd[$];
    logic [IW-1:0] exp_res[$];
    int            exp_cnt;
    bit            exp_err;

    clique_step_sequencer #(.N(TN), .IDX_W(IW), .CNT_W(CW)) u_dut (
        .clk(clk), .rst(rst), .start(start), .k(k), .adj_matrix(adj),
        .busy(busy), .done(done), .err(err), .num_cliques(num_cliques),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_i(cmd_i), .cmd_j(cmd_j), .cmd_bit(cmd_bit),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit),
        .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row)
    );

    clique_step_sequencer #(.N(8), .IDX_W(IW), .CNT_W(CW)) u_dut8 (
        .clk(clk), .rst(rst), .start(e8_start), .k(e8_k), .adj_matrix(e8_adj),
        .busy(e8_busy), .done(e8_done), .err(e8_err), .num_cliques(e8_num),
        .cmd_valid(e8_cmd_valid), .cmd_ready(1'b1), .cmd_op(e8_cmd_op),
        .cmd_i(e8_cmd_i), .cmd_j(e8_cmd_j), .cmd_bit(e8_cmd_bit),
        .rsp_valid(1'b0), .rsp_hit(1'b0),
        .res_valid(e8_res_valid), .res_ready(1'b1), .res_row(e8_res_row)
    );

    initial forever #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] pack_cmd(input logic [2:0] op, input logic [4:0] ci,
                                             input logic [4:0] cj, input logic [4:0] cb);
        return {op, ci, (op == 3'd0) ? 5'd0 : cj, (op == 3'd4) ? cb : 5'd0};
    endfunction

    function automatic bit hit_at(input int i, input int l);
        if (i < 0 || i >= TN || l < 0 || l >= TN) return 1'b0;
        return hit_v[i*TN + l];
    endfunction

    // Expected streams straight from the schedule rules: pairs, then optional scan, stop on first clique.
    task automatic build_model(input int kk, input logic [TN*TN-1:0] a);
        exp_cmd.delete();
        exp_res.delete();
        exp_cnt = 0;
        exp_err = (kk < 2) || (kk > TN);
        if (!exp_err) begin
            for (int i = 0; i < TN - 1; i++) begin
                for (int j = i + 1; j < TN; j++) begin
                    exp_cmd.push_back(pack_cmd(3'd0, 5'(i), 5'(j), 5'd0));
                    exp_cmd.push_back(pack_cmd(3'd1, 5'(i), 5'(j), 5'd0));
                    exp_cmd.push_back(pack_cmd(3'd2, 5'(i), 5'(j), 5'd0));
                    if (a[i*TN + j]) exp_cmd.push_back(pack_cmd(3'd3, 5'(i), 5'(j), 5'd0));
                end
                if (kk >= i + 2) begin
                    for (int l = i + 2; l < TN; l++) begin
                        exp_cmd.push_back(pack_cmd(3'd4, 5'(i), 5'(l), 5'(kk - i - 2)));
                        if (hit_at(i, l)) begin
                            exp_res.push_back(IW'(l));
                            if (exp_cnt < 255) exp_cnt++;
                        end
                    end
                end
                if (exp_cnt > 0) break;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            e8_cv_seen = e8_cv_seen | e8_cmd_valid;
            if (rst) begin
                cs_prev = 1'b0;
                rs_prev = 1'b0;
            end else begin
                if (cs_prev)
                    check_eq("cmd_stable", {13'd0, cmd_valid, cmd_op, cmd_i, cmd_j, cmd_bit}, cs_fields);
                cs_prev   = cmd_valid && !cmd_ready;
                cs_fields = {13'd0, cmd_valid, cmd_op, cmd_i, cmd_j, cmd_bit};
                if (rs_prev) check_eq("res_stable", {26'd0, res_valid, res_row}, rs_fields);
                rs_prev   = res_valid && !res_ready;
                rs_fields = {26'd0, res_valid, res_row};
                if (cmd_valid && cmd_ready) begin
                    n_cmd++;
                    if (cmd_op == 3'd3) n_pp++;
                    if (cmd_op == 3'd4) begin
                        n_scan++;
                        pend     = 1'b1;
                        pend_hit = hit_at(int'(cmd_i), int'(cmd_j));
                        pend_dly = rand_mode ? int'($urandom_range(0, 3)) : 0;
                    end
                    check_eq("cmd_avail", 32'(exp_cmd.size() > 0), 32'd1);
                    if (exp_cmd.size() > 0)
                        check_eq("cmd_seq", 32'(pack_cmd(cmd_op, cmd_i, cmd_j, cmd_bit)), 32'(exp_cmd.pop_front()));
                end
                if (res_valid && res_ready) begin
                    n_res++;
                    check_eq("res_avail", 32'(exp_res.size() > 0), 32'd1);
                    if (exp_res.size() > 0) check_eq("res_row", 32'(res_row), 32'(exp_res.pop_front()));
                end
                if (done) done_cnt++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cmd_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            res_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pend && !hold_rsp) begin
                if (pend_dly == 0) begin
                    rsp_valid = 1'b1;
                    rsp_hit   = pend_hit;
                    pend      = 1'b0;
                end else begin
                    pend_dly--;
                    rsp_valid = 1'b0;
                    rsp_hit   = 1'b0;
                end
            end else if (!pend && rand_mode && $urandom_range(0, 3) == 0) begin
                rsp_valid = 1'b1;
                rsp_hit   = 1'b1;
            end else begin
                rsp_valid = 1'b0;
                rsp_hit   = 1'b0;
            end
        end
    end

    task automatic launch(input int kk, input logic [TN*TN-1:0] a);
        build_model(kk, a);
        n_cmd = 0; n_pp = 0; n_scan = 0; n_res = 0;
        @(posedge clk); #1;
        start = 1'b1; k = 5'(kk); adj = a;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("busy_on", busy, 1);
        check_eq("cv_cycle1", cmd_valid, 0);
        @(posedge clk); #1;
        if (exp_err) check_eq("done_illegal", done, 1);
        else         check_eq("cv_cycle2", cmd_valid, 1);
    endtask

    task automatic finish_run(input bit spam);
        int cyc = 0;
        while (!done && cyc < LIMIT) begin
            @(posedge clk); #1;
            cyc++;
            if (spam) begin
                start = 1'b1;
                k     = 5'($urandom_range(0, 31));
                adj   = TN*TN'($urandom);
            end
        end
        check_eq("done_seen", done, 1);
        check_eq("err", err, 32'(exp_err));
        check_eq("num_cliques", num_cliques, exp_cnt);
        check_eq("cmd_left", exp_cmd.size(), 0);
        check_eq("res_left", exp_res.size(), 0);
        check_eq("busy_at_done", busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("done_one_cycle", done, 0);
        @(posedge clk); #1;
        check_eq("idle_after", busy, 0);
        check_eq("num_held", num_cliques, exp_cnt);
    endtask

    task automatic illegal8(input logic [4:0] kk);
        @(posedge clk); #1;
        e8_start = 1'b1; e8_k = kk; e8_adj = {$urandom, $urandom};
        @(posedge clk); #1;
        e8_start = 1'b0;
        check_eq("k8_busy", e8_busy, 1);
        check_eq("k8_done_early", e8_done, 0);
        @(posedge clk); #1;
        check_eq("k8_done", e8_done, 1);
        check_eq("k8_err", e8_err, 1);
        check_eq("k8_num", e8_num, 0);
        @(posedge clk); #1;
        check_eq("k8_done_pulse", e8_done, 0);
        check_eq("k8_idle", e8_busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int cyc;
        n_cmd = 0; n_pp = 0; n_scan = 0; n_res = 0; done_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_num", num_cliques, 0);
        check_eq("rst_cmd_valid", cmd_valid, 0);
        check_eq("rst_res_valid", res_valid, 0);
        rst = 1'b0;

        hit_v = '0; rand_mode = 1'b0;
        launch(3, 16'h0000);
        finish_run(1'b0);
        check_eq("empty_ncmd", n_cmd, 21);
        check_eq("empty_npp", n_pp, 0);
        check_eq("empty_nscan", n_scan, 3);

        hit_v = '0;
        hit_v[0*TN + 2] = 1'b1;
        hit_v[0*TN + 3] = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            rand_mode = (pass == 1);
            launch(3, 16'hFFFF);
            finish_run(1'b0);
            check_eq("full_ncmd", n_cmd, 14);
            check_eq("full_npp", n_pp, 3);
            check_eq("full_nscan", n_scan, 2);
            check_eq("full_nres", n_res, 2);
        end

        for (int it = 0; it < 10; it++) begin
            rand_mode = 1'b1;
            hit_v = TN*TN'($urandom);
            launch(int'($urandom_range(0, 6)), TN*TN'($urandom));
            finish_run(1'b0);
        end

        hit_v = TN*TN'($urandom);
        launch(4, 16'hFFFF);
        finish_run(1'b1);

        rand_mode = 1'b0; hold_rsp = 1'b1; hit_v = '1;
        launch(3, 16'hFFFF);
        cyc = 0;
        while (!pend && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("reached_wait", pend, 1);
        check_eq("busy_in_wait", busy, 1);
        #1;
        rst = 1'b1;
        d0 = done_cnt;
        #1;
        check_eq("arst_cmd_valid", cmd_valid, 0);
        check_eq("arst_res_valid", res_valid, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_done", done, 0);
        check_eq("arst_num", num_cliques, 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0; pend = 1'b0; hold_rsp = 1'b0;
        check_eq("no_done_on_rst", done_cnt, d0);
        hit_v = TN*TN'($urandom);
        launch(4, TN*TN'($urandom));
        finish_run(1'b0);

        illegal8(5'd1);
        illegal8(5'd9);
        check_eq("k8_no_cmd", e8_cv_seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
